// File: rtl/approx_mult_pkg.sv
// Shared definitions for the approximate tile multiplier.
// Holds the tile geometry, the constant low-bit fill used by approximate
// tiles, the tile-index helper and the tile product type.
package approx_mult_pkg;

    localparam int TILE_W = 4;
    localparam logic [2:0] APPROX_LSB_FILL = 3'b100;

    typedef logic [2*TILE_W-1:0] tile_prod_t;

    // Flat index of tile (a nibble i, b nibble j) in a T x T tile grid.
    function automatic int tile_idx(input int i, input int j, input int t);
        return i * t + j;
    endfunction

endpackage

// File: rtl/approx_mult_if.sv
// Streaming interface of the approximate multiplier.
// The master modport belongs to the operand source / result consumer side.
// The slave modport belongs to the multiplier.
interface approx_mult_if
    import approx_mult_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int ERR_W = 32
);
    localparam int T = WIDTH / TILE_W;

    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic [T*T-1:0]       mode;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   r;
    logic                 err_clr;
    logic [ERR_W-1:0]     err_acc;
    logic [ERR_W-1:0]     err_cnt;

    modport master (
        output in_valid, a, b, mode, out_ready, err_clr,
        input  in_ready, out_valid, r, err_acc, err_cnt
    );

    modport slave (
        input  in_valid, a, b, mode, out_ready, err_clr,
        output in_ready, out_valid, r, err_acc, err_cnt
    );

endinterface

// File: rtl/approx_mult_tile.sv
// Combinational 4x4 tile multiplier, exact or approximate.
// The approximate form keeps the top five bits of the exact product and
// replaces the low three with a fixed mid-point fill; a zero nibble always
// yields zero so that sparse operands stay exact.
module approx_tile_4x4
    import approx_mult_pkg::*;
(
    input  logic [TILE_W-1:0] an,
    input  logic [TILE_W-1:0] bn,
    input  logic              approx,
    output tile_prod_t        p
);

    tile_prod_t ex;

    // Exact nibble product, then optional truncation with fixed LSB fill
    always_comb begin
        ex = {{TILE_W{1'b0}}, an} * {{TILE_W{1'b0}}, bn};
        p  = ex;
        if (approx) begin
            if (an == '0 || bn == '0) begin
                p = '0;
            end else begin
                p = {ex[7:3], APPROX_LSB_FILL};
            end
        end
    end

endmodule

// File: rtl/approx_mult_pipe.sv
// Pipelined approximate unsigned multiplier, WIDTH x WIDTH -> 2*WIDTH.
// Three register stages: operands, tile products, saturated sum.
// All stages advance together whenever the output is empty or being taken.
// Optional macro APPROX_MULT_ERR_MON_EN adds an exact shadow product and
// error counters; without it err_acc/err_cnt read zero and err_clr is unused.
module approx_mult_pipe
    import approx_mult_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int ERR_W = 32
) (
    input logic          clk,
    input logic          rst,
    approx_mult_if.slave bus
);

    localparam int T  = WIDTH / TILE_W;
    localparam int NT = T * T;
    localparam int PW = 2 * WIDTH;
    localparam int SW = PW + 2;

    logic             adv;
    logic             s1_valid;
    logic             s2_valid;
    logic             s3_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [NT-1:0]    s1_mode;
    tile_prod_t       tile_p  [NT];
    tile_prod_t       s2_prod [NT];
    logic [SW-1:0]    sum;
    logic [PW-1:0]    sum_sat;
    logic [PW-1:0]    r_q;

    assign adv           = !s3_valid || bus.out_ready;
    assign bus.in_ready  = adv;
    assign bus.out_valid = s3_valid;
    assign bus.r         = r_q;

    for (genvar i = 0; i < T; i++) begin : g_row
        for (genvar j = 0; j < T; j++) begin : g_col
            approx_tile_4x4 u_tile (
                .an     (s1_a[TILE_W*i +: TILE_W]),
                .bn     (s1_b[TILE_W*j +: TILE_W]),
                .approx (s1_mode[tile_idx(i, j, T)]),
                .p      (tile_p[tile_idx(i, j, T)])
            );
        end
    end

    // Stage 1: capture operands and their mode mask together
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_mode  <= '0;
        end else if (adv) begin
            s1_valid <= bus.in_valid;
            s1_a     <= bus.a;
            s1_b     <= bus.b;
            s1_mode  <= bus.mode;
        end
    end

    // Stage 2: register every tile product
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            for (int k = 0; k < NT; k++) begin
                s2_prod[k] <= '0;
            end
        end else if (adv) begin
            s2_valid <= s1_valid;
            for (int k = 0; k < NT; k++) begin
                s2_prod[k] <= tile_p[k];
            end
        end
    end

    // Shift-and-add of all tiles with two guard bits, then clamp to all-ones
    always_comb begin
        sum = '0;
        for (int i = 0; i < T; i++) begin
            for (int j = 0; j < T; j++) begin
                sum = sum + (SW'(s2_prod[tile_idx(i, j, T)]) << (TILE_W * (i + j)));
            end
        end
        sum_sat = (|sum[SW-1:PW]) ? '1 : sum[PW-1:0];
    end

    // Stage 3: result register, only reloaded by a valid transaction
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s3_valid <= 1'b0;
            r_q      <= '0;
        end else if (adv) begin
            s3_valid <= s2_valid;
            if (s2_valid) begin
                r_q <= sum_sat;
            end
        end
    end

`ifdef APPROX_MULT_ERR_MON_EN
    logic [PW-1:0]    s2_exact;
    logic [PW-1:0]    s3_exact;
    logic [PW-1:0]    diff;
    logic [ERR_W:0]   acc_next;
    logic [ERR_W-1:0] acc_q;
    logic [ERR_W-1:0] cnt_q;

    assign bus.err_acc = acc_q;
    assign bus.err_cnt = cnt_q;

    // Exact shadow product travelling in step with the approximate one
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_exact <= '0;
            s3_exact <= '0;
        end else if (adv) begin
            s2_exact <= PW'(s1_a) * PW'(s1_b);
            if (s2_valid) begin
                s3_exact <= s2_exact;
            end
        end
    end

    // Absolute error of the presented result and the widened accumulator sum
    always_comb begin
        diff     = (s3_exact >= r_q) ? (s3_exact - r_q) : (r_q - s3_exact);
        acc_next = {1'b0, acc_q} + (ERR_W+1)'(diff);
    end

    // Saturating error counters, updated per output handshake; clear has priority
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else if (bus.err_clr) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else if (s3_valid && bus.out_ready) begin
            acc_q <= acc_next[ERR_W] ? '1 : acc_next[ERR_W-1:0];
            if (diff != '0 && cnt_q != '1) begin
                cnt_q <= cnt_q + ERR_W'(1);
            end
        end
    end
`else
    logic unused_err_clr;

    assign unused_err_clr = bus.err_clr;
    assign bus.err_acc    = '0;
    assign bus.err_cnt    = '0;
`endif

endmodule

// File: tb/tb_approx_mult_pipe.sv
// Testbench for approx_mult_pipe: an 8-bit instance driven from a table of
// hand-computed vectors plus backpressure, reset and error-clear sequences,
// and a 16-bit instance for the wide all-ones cases.
module tb_approx_mult_pipe;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [3:0]  mode;
        logic [15:0] r;
        logic [15:0] exact;
    } vec_t;

`ifdef APPROX_MULT_ERR_MON_EN
    localparam bit MON = 1'b1;
`else
    localparam bit MON = 1'b0;
`endif

    localparam int NV = 7;

    logic clk = 1'b0;
    logic rst;

    int checks   = 0;
    int failures = 0;

    longint unsigned model_acc = 0;
    longint unsigned model_cnt = 0;

    vec_t vec [NV];

    always #5 clk = ~clk;

    approx_mult_if #(.WIDTH(8),  .ERR_W(32)) bus8  ();
    approx_mult_if #(.WIDTH(16), .ERR_W(32)) bus16 ();

    approx_mult_pipe #(.WIDTH(8), .ERR_W(32)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    approx_mult_pipe #(.WIDTH(16), .ERR_W(32)) dut16 (
        .clk (clk),
        .rst (rst),
        .bus (bus16)
    );

    // Compare one value and report a mismatch
    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Present one operand set to the 8-bit DUT and hold it until accepted
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                                 input logic [3:0] mode, output bit ok);
        int n;
        bus8.a        = a;
        bus8.b        = b;
        bus8.mode     = mode;
        bus8.in_valid = 1'b1;
        n = 0;
        while (!bus8.in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus8.in_ready) begin
            checkOutput("accept_timeout", 64'd0, 64'd1);
            bus8.in_valid = 1'b0;
            ok = 1'b0;
        end else begin
            @(posedge clk); #1;
            bus8.in_valid = 1'b0;
            ok = 1'b1;
        end
    endtask

    // Wait for out_valid; lat counts edges from the accepting edge inclusive
    task automatic waitResult(output int lat);
        lat = 1;
        while (!bus8.out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    // Fold one consumed result into the error model
    task automatic modelConsume(input logic [15:0] r, input logic [15:0] exact);
        longint unsigned d;
        d = (exact > r) ? longint'(exact - r) : longint'(r - exact);
        model_acc += d;
        if (d != 0) model_cnt++;
    endtask

    // Full transaction on the 8-bit DUT with latency, result and counter checks
    task automatic runVector(input int k);
        bit ok;
        int lat;
        applyStimulus(vec[k].a, vec[k].b, vec[k].mode, ok);
        if (ok) begin
            waitResult(lat);
            checkOutput($sformatf("v%0d_latency", k), 64'(lat), 64'd3);
            checkOutput($sformatf("v%0d_r", k), 64'(bus8.r), 64'(vec[k].r));
            @(posedge clk); #1;
            modelConsume(vec[k].r, vec[k].exact);
            checkOutput($sformatf("v%0d_no_dup", k), 64'(bus8.out_valid), 64'd0);
            checkOutput($sformatf("v%0d_err_acc", k), 64'(bus8.err_acc), MON ? model_acc : 64'd0);
            checkOutput($sformatf("v%0d_err_cnt", k), 64'(bus8.err_cnt), MON ? model_cnt : 64'd0);
        end
    endtask

    // One transaction on the 16-bit DUT
    task automatic run16(input string name, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] mode, input logic [31:0] expected);
        int n;
        bus16.a        = a;
        bus16.b        = b;
        bus16.mode     = mode;
        bus16.in_valid = 1'b1;
        @(posedge clk); #1;
        bus16.in_valid = 1'b0;
        n = 1;
        while (!bus16.out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        checkOutput({name, "_latency"}, 64'(n), 64'd3);
        checkOutput({name, "_r"}, 64'(bus16.r), 64'(expected));
        @(posedge clk); #1;
    endtask

    // Hang guard
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] simulation did not complete");
    end

    // Main test sequence
    initial begin
        logic [15:0] got [3];
        int          n;
        int          cyc;
        int          stale;
        bit          ok;
        int          lat;

        vec[0] = '{8'hFF, 8'hFF, 4'b0000, 16'hFE01, 16'hFE01};
        vec[1] = '{8'h11, 8'h11, 4'b1111, 16'h0484, 16'h0121};
        vec[2] = '{8'hFF, 8'hFF, 4'b1100, 16'hFFFF, 16'hFE01};
        vec[3] = '{8'h00, 8'hA7, 4'b1111, 16'h0000, 16'h0000};
        vec[4] = '{8'h23, 8'h45, 4'b0001, 16'h096C, 16'h096F};
        vec[5] = '{8'h9C, 8'h37, 4'b0110, 16'h2154, 16'h2184};
        vec[6] = '{8'h05, 8'h03, 4'b0000, 16'h000F, 16'h000F};

        bus8.in_valid  = 1'b0;
        bus8.a         = '0;
        bus8.b         = '0;
        bus8.mode      = '0;
        bus8.out_ready = 1'b1;
        bus8.err_clr   = 1'b0;
        bus16.in_valid  = 1'b0;
        bus16.a         = '0;
        bus16.b         = '0;
        bus16.mode      = '0;
        bus16.out_ready = 1'b1;
        bus16.err_clr   = 1'b0;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_out_valid", 64'(bus8.out_valid), 64'd0);
        checkOutput("reset_r", 64'(bus8.r), 64'd0);
        checkOutput("reset_in_ready", 64'(bus8.in_ready), 64'd1);
        checkOutput("reset_err_acc", 64'(bus8.err_acc), 64'd0);
        checkOutput("reset_err_cnt", 64'(bus8.err_cnt), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        $display("[TB] table vectors");
        for (int k = 0; k < NV; k++) begin
            runVector(k);
        end

        $display("[TB] backpressure sequence");
        bus8.out_ready = 1'b0;
        bus8.mode      = 4'b0000;
        bus8.in_valid  = 1'b1;
        bus8.a = 8'd5;   bus8.b = 8'd3;
        checkOutput("bp_accept0", 64'(bus8.in_ready), 64'd1);
        @(posedge clk); #1;
        bus8.a = 8'd7;   bus8.b = 8'd9;
        checkOutput("bp_accept1", 64'(bus8.in_ready), 64'd1);
        @(posedge clk); #1;
        bus8.a = 8'd255; bus8.b = 8'd2;
        checkOutput("bp_accept2", 64'(bus8.in_ready), 64'd1);
        @(posedge clk); #1;
        bus8.in_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            checkOutput($sformatf("bp_in_ready_c%0d", c), 64'(bus8.in_ready), 64'd0);
            checkOutput($sformatf("bp_hold_r_c%0d", c), 64'(bus8.r), 64'd15);
            @(posedge clk); #1;
        end
        bus8.out_ready = 1'b1;
        n   = 0;
        cyc = 0;
        while (n < 3 && cyc < 20) begin
            if (bus8.out_valid) begin
                got[n] = bus8.r;
                n++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        checkOutput("bp_count", 64'(n), 64'd3);
        checkOutput("bp_r0", 64'(got[0]), 64'd15);
        checkOutput("bp_r1", 64'(got[1]), 64'd63);
        checkOutput("bp_r2", 64'(got[2]), 64'd510);
        checkOutput("bp_drained", 64'(bus8.out_valid), 64'd0);

        $display("[TB] error clear sequence");
        runVector(2);
        applyStimulus(vec[1].a, vec[1].b, vec[1].mode, ok);
        waitResult(lat);
        checkOutput("clr_r", 64'(bus8.r), 64'(vec[1].r));
        bus8.err_clr = 1'b1;
        @(posedge clk); #1;
        bus8.err_clr = 1'b0;
        model_acc = 0;
        model_cnt = 0;
        checkOutput("clr_err_acc", 64'(bus8.err_acc), 64'd0);
        checkOutput("clr_err_cnt", 64'(bus8.err_cnt), 64'd0);
        runVector(4);

        $display("[TB] reset with transactions in flight");
        bus8.out_ready = 1'b0;
        bus8.mode      = 4'b0000;
        bus8.a = 8'h12; bus8.b = 8'h34;
        bus8.in_valid = 1'b1;
        @(posedge clk); #1;
        bus8.a = 8'h56; bus8.b = 8'h78;
        @(posedge clk); #1;
        bus8.in_valid = 1'b0;
        @(posedge clk); #1;
        checkOutput("rst_pre_out_valid", 64'(bus8.out_valid), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rst_out_valid", 64'(bus8.out_valid), 64'd0);
        checkOutput("rst_in_ready", 64'(bus8.in_ready), 64'd1);
        checkOutput("rst_err_acc", 64'(bus8.err_acc), 64'd0);
        model_acc = 0;
        model_cnt = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        bus8.out_ready = 1'b1;
        stale = 0;
        for (int c = 0; c < 8; c++) begin
            if (bus8.out_valid) stale++;
            @(posedge clk); #1;
        end
        checkOutput("rst_no_stale", 64'(stale), 64'd0);
        runVector(0);

        $display("[TB] 16-bit instance");
        run16("w16_exact", 16'hFFFF, 16'hFFFF, 16'h0000, 32'hFFFE0001);
        run16("w16_sat",   16'hFFFF, 16'hFFFF, 16'hF000, 32'hFFFFFFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
